// File: rtl/wave_key_sel.sv
// ============================================================================
// wave_key_sel: debounced NEXT/PREV selector for the three-bank wave sender.
// Optional macro WAVE_KEY_LED_EN adds a registered one-hot led[2:0] port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wave_key_sel #(
  parameter logic [19:0] DEB_CYCLES = 20'd1_000_000,
  parameter logic [1:0]  INIT_WAVE  = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_next,
  input  logic       key_prev,
  output logic [1:0] wave_flag,
  output logic       wave_chg
`ifdef WAVE_KEY_LED_EN
  ,
  output logic [2:0] led
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DEB_DN = 2'd1,
    S_HELD   = 2'd2,
    S_DEB_UP = 2'd3
  } deb_state_t;

  logic [1:0] keys_raw;
  logic [1:0] press;

  assign keys_raw = {key_prev, key_next};

  generate
    for (genvar k = 0; k < 2; k++) begin : g_key
      logic        sync1;
      logic        key_s;
      deb_state_t  state;
      deb_state_t  state_nxt;
      logic [19:0] cnt;
      logic [19:0] cnt_nxt;
      logic        press_k;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b1;
          key_s <= 1'b1;
          state <= S_IDLE;
          cnt   <= 20'd0;
        end else begin
          sync1 <= keys_raw[k];
          key_s <= sync1;
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      // cnt saturates at DEB_CYCLES-1: the transition out of a debounce state
      // happens in the same cycle the terminal count is seen.
      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_k   = 1'b0;
        case (state)
          S_IDLE: begin
            if (!key_s) begin
              cnt_nxt   = 20'd0;
              state_nxt = S_DEB_DN;
            end
          end
          S_DEB_DN: begin
            if (key_s) begin
              state_nxt = S_IDLE;
            end else if (cnt == DEB_CYCLES - 20'd1) begin
              press_k   = 1'b1;
              state_nxt = S_HELD;
            end else begin
              cnt_nxt = cnt + 20'd1;
            end
          end
          S_HELD: begin
            if (key_s) begin
              cnt_nxt   = 20'd0;
              state_nxt = S_DEB_UP;
            end
          end
          S_DEB_UP: begin
            if (!key_s) begin
              state_nxt = S_HELD;
            end else if (cnt == DEB_CYCLES - 20'd1) begin
              state_nxt = S_IDLE;
            end else begin
              cnt_nxt = cnt + 20'd1;
            end
          end
          default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = 20'd0;
          end
        endcase
      end

      assign press[k] = press_k;
    end
  endgenerate

  logic [1:0] flag_nxt;
  logic       chg_nxt;

  // Simultaneous NEXT and PREV cancel out; value 3 is forced back to bank 0.
  always_comb begin
    flag_nxt = wave_flag;
    chg_nxt  = 1'b0;
    if (wave_flag == 2'd3) begin
      flag_nxt = 2'd0;
      chg_nxt  = 1'b1;
    end else if (press == 2'b01) begin
      flag_nxt = (wave_flag == 2'd2) ? 2'd0 : wave_flag + 2'd1;
      chg_nxt  = 1'b1;
    end else if (press == 2'b10) begin
      flag_nxt = (wave_flag == 2'd0) ? 2'd2 : wave_flag - 2'd1;
      chg_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_flag <= INIT_WAVE;
      wave_chg  <= 1'b0;
    end else begin
      wave_flag <= flag_nxt;
      wave_chg  <= chg_nxt;
    end
  end

`ifdef WAVE_KEY_LED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= 3'b001 << INIT_WAVE;
    end else begin
      led <= 3'b001 << flag_nxt;
    end
  end
`endif

endmodule

`default_nettype wire
